tlc_prog_timer: RTL and testbench



---
 rtl/tlc_timer_pkg.sv | 23 ++
 rtl/tlc_prescaler.sv | 48 ++++
 rtl/tlc_prog_timer.sv | 139 +++++++++++++
 tb/tb_tlc_prog_timer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_timer_pkg.sv
// Shared constants for the traffic-light phase timer: FSM encoding,
// mode encoding and default widths.
package tlc_timer_pkg;

  // Default widths: count/final_value and prescaler.
  localparam int N_DEF = 13;
  localparam int P_DEF = 16;

  // FSM encoding. 2'b11 is unused and recovers to IDLE.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Timing mode, latched on start.
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  // True while a phase is being timed (running or frozen).
  function automatic logic is_active(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_PAUSE);
  endfunction

endpackage

// File: rtl/tlc_prescaler.sv
// P-bit clock divider. While enabled it counts 0..limit and asserts tick
// combinationally during the cycle the counter equals limit, wrapping to 0
// on that edge. Clear has priority and forces the counter to 0.
module tlc_prescaler
  import tlc_timer_pkg::*;
#(
  parameter int P = P_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [P-1:0] limit,
  output logic         tick
);

  localparam logic [P-1:0] PSC_ONE = {{(P-1){1'b0}}, 1'b1};

  logic [P-1:0] psc_q;
  logic [P-1:0] psc_d;

  // Tick fires on the last prescaler count of each period.
  assign tick = en && (psc_q == limit);

  // Next prescaler value: clear, wrap on tick, increment, or hold.
  always_comb begin
    psc_d = psc_q;
    if (clr) begin
      psc_d = '0;
    end else if (en) begin
      if (tick) begin
        psc_d = '0;
      end else begin
        psc_d = psc_q + PSC_ONE;
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/tlc_prog_timer.sv
// Programmable phase timer for the traffic-light controller.
//
// Control protocol: start and abort are single-cycle pulses sampled on the
// rising clock edge; pause is a level. When several are high on the same
// edge, abort beats start, start beats pause, and pause beats a tick.
// final_value, prescale and mode are only sampled on an edge with start
// high (and abort low); they may change freely at any other time.
// timer_done is a registered one-cycle pulse following the terminal tick.
//
// The PAUSE state means "pause was high at the last edge". The edge that
// leaves PAUSE (pause low) already advances the prescaler, so the phase
// stretches by exactly the number of edges pause was sampled high.
module tlc_prog_timer
  import tlc_timer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int P = P_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic         mode,
  input  logic [N-1:0] final_value,
  input  logic [P-1:0] prescale,
  output logic         busy,
  output logic         paused,
  output logic [N-1:0] count,
  output logic         timer_done
);

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state_q, state_d;
  logic [N-1:0] fv_q, fv_d;
  logic [P-1:0] ps_q, ps_d;
  logic         md_q, md_d;
  logic [N-1:0] count_q, count_d;
  logic         done_q, done_d;

  logic         run_en;
  logic         psc_clr;
  logic         tick;

  // Prescaler runs whenever a phase is active and pause is low; it is held
  // at zero in IDLE and on every start/abort.
  assign run_en  = is_active(state_q) && !pause;
  assign psc_clr = start || abort || (state_q == ST_IDLE);

  tlc_prescaler #(
    .P (P)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (run_en),
    .clr   (psc_clr),
    .limit (ps_q),
    .tick  (tick)
  );

  // FSM, config latch, count and done pulse next-state logic.
  always_comb begin
    state_d = state_q;
    fv_d    = fv_q;
    ps_d    = ps_q;
    md_d    = md_q;
    count_d = count_q;
    done_d  = 1'b0;

    if (abort) begin
      // Cancel: any tick on this edge is discarded.
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start) begin
      // (Re)start from any state with freshly latched config.
      fv_d    = final_value;
      ps_d    = prescale;
      md_d    = mode;
      count_d = '0;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Pause is meaningless here; count keeps its last value.
        end
        ST_RUN, ST_PAUSE: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
            if (tick) begin
              if (count_q == fv_q) begin
                done_d = 1'b1;
                if (md_q == MODE_RELOAD) begin
                  count_d = '0;
                end else begin
                  // One-shot: finish with count parked at final value.
                  state_d = ST_IDLE;
                end
              end else begin
                count_d = count_q + CNT_ONE;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State, config and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fv_q    <= '0;
      ps_q    <= '0;
      md_q    <= MODE_ONESHOT;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fv_q    <= fv_d;
      ps_q    <= ps_d;
      md_q    <= md_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign busy       = is_active(state_q);
  assign paused     = (state_q == ST_PAUSE);
  assign count      = count_q;
  assign timer_done = done_q;

endmodule

// File: tb/tb_tlc_prog_timer.sv
// Directed bench for tlc_prog_timer. Cycle c is the interval after the c-th
// rising edge counted from the edge that sampled start (c = 0). Observed
// vector is {busy, paused, timer_done, count}.
module tb_tlc_prog_timer;
  import tlc_timer_pkg::*;

  localparam int N = 13;
  localparam int P = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         pause;
  logic         abort;
  logic         mode;
  logic [N-1:0] final_value;
  logic [P-1:0] prescale;
  logic         busy;
  logic         paused;
  logic [N-1:0] count;
  logic         timer_done;

  logic [N+2:0] obs;
  int           n_tests = 0;
  int           n_fail  = 0;

  tlc_prog_timer #(.N(N), .P(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .mode        (mode),
    .final_value (final_value),
    .prescale    (prescale),
    .busy        (busy),
    .paused      (paused),
    .count       (count),
    .timer_done  (timer_done)
  );

  // Clock and observation vector.
  always #5 clk = ~clk;
  assign obs = {busy, paused, timer_done, count};

  function automatic logic [N+2:0] exp_v(input logic b, input logic p,
                                         input logic d, input int c);
    return {b, p, d, c[N-1:0]};
  endfunction

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; afterwards the bench is in cycle 0.
  task automatic do_start(input int f, input int ps, input logic m);
    final_value = f[N-1:0];
    prescale    = ps[P-1:0];
    mode        = m;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic test_reset();
    logic [N+2:0] e;
    reset = 1'b1; start = 0; pause = 0; abort = 0; mode = 0;
    final_value = '0; prescale = '0;
    repeat (2) step();
    e = exp_v(0, 0, 0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_held got %h want %h", obs, e); end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_released got %h want %h", obs, e); end
  endtask

  // F=4 PS=0 one-shot; config inputs scrambled after start must not matter.
  task automatic test_oneshot();
    logic [N+2:0] e;
    do_start(4, 0, MODE_ONESHOT);
    for (int c = 0; c < 9; c++) begin
      e = exp_v(c < 5, 0, c == 5, (c < 4) ? c : 4);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL oneshot cyc %0d got %h want %h", c, obs, e); end
      if (c == 1) begin final_value = 7; prescale = 3; mode = MODE_RELOAD; end
      step();
    end
  endtask

  // F=2 PS=3 reload: count steps every 4 clks, done every 12.
  task automatic test_reload();
    logic [N+2:0] e;
    do_start(2, 3, MODE_RELOAD);
    for (int c = 0; c < 38; c++) begin
      e = exp_v(1, 0, (c > 0) && (c % 12 == 0), (c / 4) % 3);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL reload cyc %0d got %h want %h", c, obs, e); end
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    e = exp_v(0, 0, 0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reload_abort got %h want %h", obs, e); end
  endtask

  // F=9 PS=0 one-shot, pause sampled high on edges 4..8: done moves 10 -> 15.
  task automatic test_pause();
    logic [N+2:0] e;
    int ec;
    do_start(9, 0, MODE_ONESHOT);
    for (int c = 0; c < 18; c++) begin
      ec = (c <= 3) ? c : (c <= 8) ? 3 : (c <= 14) ? c - 5 : 9;
      e = exp_v(c < 15, (c >= 4) && (c <= 8), c == 15, ec);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL pause cyc %0d got %h want %h", c, obs, e); end
      pause = (c >= 3) && (c <= 7);
      step();
    end
    pause = 1'b0;
  endtask

  // F=9 PS=1 aborted at edge 6, then F=1 PS=1 re-times from zero.
  task automatic test_abort();
    logic [N+2:0] e;
    do_start(9, 1, MODE_ONESHOT);
    for (int c = 0; c < 26; c++) begin
      e = exp_v(c < 6, 0, 0, (c < 6) ? c / 2 : 0);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL abort cyc %0d got %h want %h", c, obs, e); end
      abort = (c == 5);
      step();
    end
    abort = 1'b0;
    do_start(1, 1, MODE_ONESHOT);
    for (int r = 0; r < 6; r++) begin
      e = exp_v(r < 4, 0, r == 4, (r < 2) ? 0 : 1);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL abort_restart cyc %0d got %h want %h", r, obs, e); end
      step();
    end
  endtask

  // Abort on the terminal edge of a reload run: no done, count and psc cleared.
  task automatic test_abort_terminal();
    logic [N+2:0] e;
    do_start(1, 0, MODE_RELOAD);
    for (int c = 0; c < 4; c++) begin
      e = (c < 2) ? exp_v(1, 0, 0, c) : exp_v(0, 0, 0, 0);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL abort_terminal cyc %0d got %h want %h", c, obs, e); end
      abort = (c == 1);
      step();
    end
    abort = 1'b0;
  endtask

  // F=3 PS=0: restart on the terminal edge suppresses done; done lands at 8.
  task automatic test_restart_terminal();
    logic [N+2:0] e;
    do_start(3, 0, MODE_ONESHOT);
    for (int c = 0; c < 11; c++) begin
      if (c < 4)       e = exp_v(1, 0, 0, c);
      else if (c == 4) e = exp_v(1, 0, 0, 0);
      else if (c < 8)  e = exp_v(1, 0, 0, c - 4);
      else             e = exp_v(0, 0, c == 8, 3);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL restart cyc %0d got %h want %h", c, obs, e); end
      if (c == 1) final_value = 6;
      if (c == 3) final_value = 3;
      start = (c == 3);
      step();
    end
    start = 1'b0;
  endtask

  // F=2 PS=0: pause on the would-be terminal edge defers done until resume.
  task automatic test_pause_terminal();
    logic [N+2:0] e;
    do_start(2, 0, MODE_ONESHOT);
    for (int c = 0; c < 7; c++) begin
      if (c < 3)       e = exp_v(1, 0, 0, c);
      else if (c < 5)  e = exp_v(1, 1, 0, 2);
      else             e = exp_v(0, 0, c == 5, 2);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL pause_terminal cyc %0d got %h want %h", c, obs, e); end
      pause = (c == 2) || (c == 3);
      step();
    end
    pause = 1'b0;
  endtask

  // Start with pause high enters RUN then PAUSE; pause in IDLE is ignored.
  task automatic test_start_while_pause();
    logic [N+2:0] e;
    pause = 1'b1;
    do_start(1, 0, MODE_ONESHOT);
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       e = exp_v(1, 0, 0, 0);
        1:       e = exp_v(1, 1, 0, 0);
        2:       e = exp_v(1, 0, 0, 1);
        3:       e = exp_v(0, 0, 1, 1);
        default: e = exp_v(0, 0, 0, 1);
      endcase
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL start_pause cyc %0d got %h want %h", c, obs, e); end
      pause = (c < 1) || ((c >= 3) && (c <= 4));
      step();
    end
    pause = 1'b0;
  endtask

  // Largest final value with PS=0: 8192 cycles, count parks at 8191, no wrap.
  task automatic test_max_final();
    logic [N+2:0] e;
    do_start(8191, 0, MODE_ONESHOT);
    for (int c = 0; c < 8191; c++) step();
    e = exp_v(1, 0, 0, 8191);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL max_final_pre got %h want %h", obs, e); end
    step();
    e = exp_v(0, 0, 1, 8191);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL max_final_done got %h want %h", obs, e); end
    step();
    e = exp_v(0, 0, 0, 8191);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL max_final_post got %h want %h", obs, e); end
  endtask

  // Async reset between edges during F=0 PS=0 reload, then done every cycle.
  task automatic test_reset_midrun();
    logic [N+2:0] e;
    do_start(0, 0, MODE_RELOAD);
    repeat (2) step();
    e = exp_v(1, 0, 1, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL midrun_pre got %h want %h", obs, e); end
    #2 reset = 1'b1;
    #1;
    e = exp_v(0, 0, 0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL midrun_async got %h want %h", obs, e); end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL midrun_idle got %h want %h", obs, e); end
    do_start(0, 0, MODE_RELOAD);
    for (int c = 0; c < 6; c++) begin
      e = exp_v(1, 0, c > 0, 0);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL f0_reload cyc %0d got %h want %h", c, obs, e); end
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_pause();
    test_abort();
    test_abort_terminal();
    test_restart_terminal();
    test_pause_terminal();
    test_start_while_pause();
    test_max_final();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
